// File: rtl/moore_seq_detector_pkg.sv
// Shared types and helpers for the serial pattern detector: state phase,
// prefix_len width helper and the longest-prefix match function.
package moore_seq_pkg;

    localparam int MAX_PAT_W = 16;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_PARTIAL = 2'd1,
        PH_DETECT  = 2'd2
    } phase_e;

    function automatic int plen_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // hist holds the newest bit in bit 0; pattern bit pat_w-1 is the first bit on the wire,
    // so the newest L history bits line up with pattern[pat_w-1 -: L] shifted down.
    function automatic int prefix_match(input logic [MAX_PAT_W-1:0] hist,
                                        input int                   hvalid,
                                        input logic [MAX_PAT_W-1:0] pattern,
                                        input int                   pat_w);
        int                   best;
        logic [MAX_PAT_W-1:0] top;
        logic [MAX_PAT_W-1:0] keep;
        best = 0;
        for (int l = 1; l <= MAX_PAT_W; l++) begin
            if (l <= pat_w && l <= hvalid) begin
                top  = pattern >> (pat_w - l);
                keep = ~({MAX_PAT_W{1'b1}} << l);
                if (((hist ^ top) & keep) == '0) begin
                    best = l;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// Serial stream and control bundle between a stimulus source and the detector.
// din is sampled only on edges where en is high; load overrides en; outputs are registered.
interface moore_seq_detector_if
    import moore_seq_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    localparam int PLEN_W = plen_w(PAT_W);

    logic              load;
    logic [PAT_W-1:0]  pattern_in;
    logic              overlap_in;
    logic              en;
    logic              din;
    logic              dout;
    logic [CNT_W-1:0]  match_count;
    logic [PLEN_W-1:0] prefix_len;
    phase_e            phase;

    modport master (
        output load, pattern_in, overlap_in, en, din,
        input  dout, match_count, prefix_len, phase
    );

    modport slave (
        input  load, pattern_in, overlap_in, en, din,
        output dout, match_count, prefix_len, phase
    );

endinterface

// File: rtl/moore_seq_next.sv
// Combinational next-state logic: shifts din into the history and finds the
// longest matched pattern prefix. Holds no state.
module moore_seq_next
    import moore_seq_pkg::*;
#(
    parameter int PAT_W  = 3,
    parameter int PLEN_W = 2
) (
    input  logic [PAT_W-1:0]  hist,
    input  logic              din,
    input  logic [PLEN_W-1:0] hvalid,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    input  logic              in_detect,
    output logic [PAT_W-1:0]  next_hist,
    output logic [PLEN_W-1:0] next_hvalid,
    output logic [PLEN_W-1:0] next_len,
    output logic              enter_detect
);

    logic [PLEN_W-1:0] eff_hvalid;
    int                match_len;

    always_comb begin
        // Without overlap, a completed match leaves nothing to build on.
        eff_hvalid   = (in_detect && !overlap) ? '0 : hvalid;
        next_hist    = {hist[PAT_W-2:0], din};
        next_hvalid  = (eff_hvalid == PLEN_W'(PAT_W)) ? eff_hvalid : eff_hvalid + PLEN_W'(1);
        match_len    = prefix_match(MAX_PAT_W'(next_hist), int'(next_hvalid),
                                    MAX_PAT_W'(pattern), PAT_W);
        next_len     = PLEN_W'(match_len);
        enter_detect = (match_len == PAT_W);
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with loadable pattern, overlap mode, enable
// and saturating match counter. All registers live here.
module moore_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int               PAT_W       = 3,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(5),
    parameter logic             RST_OVERLAP = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    moore_seq_detector_if.slave  bus
);

    localparam int PLEN_W = plen_w(PAT_W);

    logic [PAT_W-1:0]  pattern_q;
    logic              overlap_q;
    logic [PAT_W-1:0]  hist_q;
    logic [PLEN_W-1:0] hvalid_q;
    logic [PLEN_W-1:0] len_q;
    phase_e            phase_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [PAT_W-1:0]  next_hist;
    logic [PLEN_W-1:0] next_hvalid;
    logic [PLEN_W-1:0] next_len;
    logic              enter_detect;

    moore_seq_next #(
        .PAT_W  (PAT_W),
        .PLEN_W (PLEN_W)
    ) u_next (
        .hist         (hist_q),
        .din          (bus.din),
        .hvalid       (hvalid_q),
        .pattern      (pattern_q),
        .overlap      (overlap_q),
        .in_detect    (phase_q == PH_DETECT),
        .next_hist    (next_hist),
        .next_hvalid  (next_hvalid),
        .next_len     (next_len),
        .enter_detect (enter_detect)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= RST_PATTERN;
            overlap_q <= RST_OVERLAP;
            hist_q    <= '0;
            hvalid_q  <= '0;
            len_q     <= '0;
            phase_q   <= PH_IDLE;
            cnt_q     <= '0;
        end else if (bus.load) begin
            pattern_q <= bus.pattern_in;
            overlap_q <= bus.overlap_in;
            hist_q    <= '0;
            hvalid_q  <= '0;
            len_q     <= '0;
            phase_q   <= PH_IDLE;
            cnt_q     <= '0;
        end else if (bus.en) begin
            hist_q   <= next_hist;
            hvalid_q <= next_hvalid;
            len_q    <= next_len;
            if (enter_detect) begin
                phase_q <= PH_DETECT;
            end else if (next_len == '0) begin
                phase_q <= PH_IDLE;
            end else begin
                phase_q <= PH_PARTIAL;
            end
            if (enter_detect && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.dout        = (phase_q == PH_DETECT);
    assign bus.match_count = cnt_q;
    assign bus.prefix_len  = len_q;
    assign bus.phase       = phase_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: three parameterisations driven from
// one vector table, plus hand-written counter-saturation sequence.
module tb_moore_seq_detector;
    import moore_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    moore_seq_detector_if #(.PAT_W(3), .CNT_W(8)) if_a ();
    moore_seq_detector_if #(.PAT_W(4), .CNT_W(8)) if_b ();
    moore_seq_detector_if #(.PAT_W(2), .CNT_W(2)) if_c ();

    moore_seq_detector #(.PAT_W(3), .CNT_W(8), .RST_PATTERN(3'b101), .RST_OVERLAP(1'b0))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    moore_seq_detector #(.PAT_W(4), .CNT_W(8), .RST_PATTERN(4'b1001), .RST_OVERLAP(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    moore_seq_detector #(.PAT_W(2), .CNT_W(2), .RST_PATTERN(2'b11), .RST_OVERLAP(1'b1))
        dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    typedef struct {
        int         sel;
        logic       rst;
        logic       load;
        logic [15:0] pat;
        logic       ovl;
        logic       en;
        logic       din;
        logic       exp_dout;
        logic [7:0] exp_cnt;
        logic [7:0] exp_plen;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;

    function automatic void add(input int sel, input logic r, input logic ld, input logic [15:0] pat,
                                input logic ovl, input logic e, input logic d,
                                input logic xd, input logic [7:0] xc, input logic [7:0] xp);
        vec_t v;
        v.sel = sel; v.rst = r; v.load = ld; v.pat = pat; v.ovl = ovl; v.en = e; v.din = d;
        v.exp_dout = xd; v.exp_cnt = xc; v.exp_plen = xp;
        vecs.push_back(v);
    endfunction

    task automatic drive(input int sel, input logic ld, input logic [15:0] pat,
                         input logic ovl, input logic e, input logic d);
        if_a.load = (sel == 0) && ld; if_a.pattern_in = pat[2:0]; if_a.overlap_in = ovl;
        if_a.en   = (sel == 0) && e;  if_a.din = d;
        if_b.load = (sel == 1) && ld; if_b.pattern_in = pat[3:0]; if_b.overlap_in = ovl;
        if_b.en   = (sel == 1) && e;  if_b.din = d;
        if_c.load = (sel == 2) && ld; if_c.pattern_in = pat[1:0]; if_c.overlap_in = ovl;
        if_c.en   = (sel == 2) && e;  if_c.din = d;
    endtask

    task automatic sample(input int sel, output logic d, output logic [7:0] c, output logic [7:0] p);
        case (sel)
            0:       begin d = if_a.dout; c = if_a.match_count;     p = 8'(if_a.prefix_len); end
            1:       begin d = if_b.dout; c = if_b.match_count;     p = 8'(if_b.prefix_len); end
            default: begin d = if_c.dout; c = 8'(if_c.match_count); p = 8'(if_c.prefix_len); end
        endcase
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int sel,
                             input logic xd, input logic [7:0] xc, input logic [7:0] xp);
        logic       d;
        logic [7:0] c;
        logic [7:0] p;
        sample(sel, d, c, p);
        check({tag, "_dout"}, 8'(d), 8'(xd));
        check({tag, "_cnt"},  c, xc);
        check({tag, "_plen"}, p, xp);
    endtask

    initial begin
        logic       d;
        logic [7:0] c;
        logic [7:0] p;

        // Test 1: defaults 101 non-overlap, stream 101101001
        add(0,0,0,0,0,1,1, 0,0,1); add(0,0,0,0,0,1,0, 0,0,2); add(0,0,0,0,0,1,1, 1,1,3);
        add(0,0,0,0,0,1,1, 0,1,1); add(0,0,0,0,0,1,0, 0,1,2); add(0,0,0,0,0,1,1, 1,2,3);
        add(0,0,0,0,0,1,0, 0,2,0); add(0,0,0,0,0,1,0, 0,2,0); add(0,0,0,0,0,1,1, 0,2,1);
        // Test 2: 101 overlap then non-overlap, stream 10101
        add(0,0,1,16'h5,1,1,0, 0,0,0);
        add(0,0,0,0,0,1,1, 0,0,1); add(0,0,0,0,0,1,0, 0,0,2); add(0,0,0,0,0,1,1, 1,1,3);
        add(0,0,0,0,0,1,0, 0,1,2); add(0,0,0,0,0,1,1, 1,2,3);
        add(0,0,1,16'h5,0,1,0, 0,0,0);
        add(0,0,0,0,0,1,1, 0,0,1); add(0,0,0,0,0,1,0, 0,0,2); add(0,0,0,0,0,1,1, 1,1,3);
        add(0,0,0,0,0,1,0, 0,1,0); add(0,0,0,0,0,1,1, 0,1,1);
        // Test 3: PAT_W=4, 1101 overlap, stream 1101101
        add(1,0,1,16'hD,1,1,0, 0,0,0);
        add(1,0,0,0,0,1,1, 0,0,1); add(1,0,0,0,0,1,1, 0,0,2); add(1,0,0,0,0,1,0, 0,0,3);
        add(1,0,0,0,0,1,1, 1,1,4); add(1,0,0,0,0,1,1, 0,1,2); add(1,0,0,0,0,1,0, 0,1,3);
        add(1,0,0,0,0,1,1, 1,2,4);
        // Test 5a: stall mid-prefix and stall in DETECT
        add(0,0,1,16'h5,0,1,0, 0,0,0);
        add(0,0,0,0,0,1,1, 0,0,1); add(0,0,0,0,0,1,0, 0,0,2);
        add(0,0,0,0,0,0,1, 0,0,2); add(0,0,0,0,0,0,1, 0,0,2); add(0,0,0,0,0,0,1, 0,0,2);
        add(0,0,0,0,0,1,1, 1,1,3);
        add(0,0,0,0,0,0,0, 1,1,3); add(0,0,0,0,0,0,0, 1,1,3);
        add(0,0,0,0,0,1,0, 0,1,0);
        // Test 5b: mid-stream reset discards the prefix
        add(0,0,1,16'h5,0,1,0, 0,0,0);
        add(0,0,0,0,0,1,1, 0,0,1); add(0,0,0,0,0,1,0, 0,0,2);
        add(0,1,0,0,0,1,1, 0,0,0);
        add(0,0,0,0,0,1,1, 0,0,1); add(0,0,0,0,0,1,0, 0,0,2); add(0,0,0,0,0,1,1, 1,1,3);
        // Reset beats load: pattern must come back as 101
        add(0,1,1,16'h2,1,1,1, 0,0,0);
        add(0,0,0,0,0,1,1, 0,0,1); add(0,0,0,0,0,1,0, 0,0,2); add(0,0,0,0,0,1,1, 1,1,3);
        // Test 6: load mid-prefix with din=1 ignored, then 011 detects
        add(0,0,1,16'h5,0,1,0, 0,0,0);
        add(0,0,0,0,0,1,1, 0,0,1); add(0,0,0,0,0,1,0, 0,0,2);
        add(0,0,1,16'h3,0,1,1, 0,0,0);
        add(0,0,0,0,0,1,0, 0,0,1); add(0,0,0,0,0,1,1, 0,0,2); add(0,0,0,0,0,1,1, 1,1,3);
        add(0,0,1,16'h5,0,1,1, 0,0,0);

        drive(0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset_a", 0, 1'b0, 8'd0, 8'd0);
        check_all("reset_b", 1, 1'b0, 8'd0, 8'd0);
        check_all("reset_c", 2, 1'b0, 8'd0, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            drive(vecs[i].sel, vecs[i].load, vecs[i].pat, vecs[i].ovl, vecs[i].en, vecs[i].din);
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].sel, vecs[i].exp_dout,
                      vecs[i].exp_cnt, vecs[i].exp_plen);
        end
        rst = 1'b0;

        // Test 4: CNT_W=2, pattern 11 overlap, eight 1s saturate the counter
        drive(2, 1'b1, 16'h3, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_all("sat_load", 2, 1'b0, 8'd0, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back((k - 1 > 3) ? 8'd3 : 8'(k - 1));
            drive(2, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            sample(2, d, c, p);
            check($sformatf("sat%0d_dout", k), 8'(d), (k >= 2) ? 8'd1 : 8'd0);
            check($sformatf("sat%0d_plen", k), p, (k >= 2) ? 8'd2 : 8'd1);
            check($sformatf("sat%0d_cnt", k), c, exp_q.pop_front());
        end
        drive(2, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_all("sat_end", 2, 1'b0, 8'd3, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
